// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encoding and default ack timeout.
package uart_sched_pkg;
    localparam logic [1:0] S_ARB  = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DEF_ACK_TIMEOUT = 16;
endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin selector with packet lock; returns a one-hot grant and its index.
module rr_arbiter_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    input  logic         lock_i,
    input  logic [2:0]   lock_idx_i,
    output logic [N-1:0] grant_o,
    output logic [2:0]   idx_o,
    output logic         valid_o
);
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        if (lock_i) begin
            for (int i = 0; i < N; i++) begin
                if (lock_idx_i == 3'(i) && req_i[i]) begin
                    grant_o[i] = 1'b1;
                    idx_o      = 3'(i);
                    valid_o    = 1'b1;
                end
            end
        end else begin
            // Wrapped requests below the pointer first; a hit at/above the pointer overrides.
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i] && 3'(i) < ptr_i) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                    idx_o      = 3'(i);
                    valid_o    = 1'b1;
                end
            end
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i] && 3'(i) >= ptr_i) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                    idx_o      = 3'(i);
                    valid_o    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_send transmitter among N_REQ byte requesters with round-robin and packet lock.
// Handshake: a byte moves when REQ_VALID[i] and REQ_READY[i] are both high on a rising CLK edge.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [8*N_REQ-1:0]   REQ_DATA,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [N_REQ-1:0]     REQ_LAST,
    output logic [N_REQ-1:0]     REQ_READY,
    output logic [7:0]           UART_DATA,
    output logic                 UART_DATA_READY,
    input  logic                 UART_IDLE,
    output logic [N_REQ-1:0]     GRANT,
    output logic                 BUSY,
    output logic                 TIMEOUT_ERR,
    input  logic                 ERR_CLR,
    output logic [1:0]           DBG_STATE
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             lock_q, lock_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_grant;
    logic [2:0]       arb_idx;
    logic             arb_valid;
    logic             transfer;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             err_set;

    rr_arbiter_n #(.N(N_REQ)) u_arb (
        .req_i      (REQ_VALID),
        .ptr_i      (ptr_q),
        .lock_i     (lock_q),
        .lock_idx_i (owner_q),
        .grant_o    (arb_grant),
        .idx_o      (arb_idx),
        .valid_o    (arb_valid)
    );

    assign transfer = RST && (state_q == S_ARB) && UART_IDLE && arb_valid;
    assign sel_last = |(REQ_LAST & arb_grant);

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) sel_data = REQ_DATA[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        timer_d = timer_q;
        err_set = 1'b0;
        case (state_q)
            S_ARB: begin
                if (transfer) begin
                    data_d  = sel_data;
                    grant_d = arb_grant;
                    owner_d = arb_idx;
                    state_d = S_SEND;
                    lock_d  = !sel_last;
                    if (sel_last) ptr_d = (arb_idx == 3'(N_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
                end
            end
            S_SEND: begin
                timer_d = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!UART_IDLE) begin
                    state_d = S_DONE;
                end else if (timer_q == T_LAST) begin
                    // uart_send never acknowledged: drop the byte, keep the lock as it was.
                    err_set = 1'b1;
                    state_d = S_ARB;
                    if (!lock_q) grant_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (UART_IDLE) begin
                    state_d = S_ARB;
                    if (!lock_q) grant_d = '0;
                end
            end
        endcase
        err_d = err_q;
        if (ERR_CLR) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_ARB;
            data_q  <= 8'h00;
            grant_q <= '0;
            lock_q  <= 1'b0;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign REQ_READY       = transfer ? arb_grant : '0;
    assign UART_DATA       = data_q;
    assign UART_DATA_READY = RST && (state_q == S_SEND);
    assign GRANT           = grant_q;
    assign BUSY            = (state_q != S_ARB);
    assign TIMEOUT_ERR     = err_q;
    assign DBG_STATE       = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of arbitration vectors plus multi-cycle sequences.
module tb_uart_tx_scheduler;
    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [7:0]  uart_data;
    logic        uart_data_ready, uart_idle, busy, timeout_err, err_clr;
    logic [1:0]  dbg_state;

    uart_tx_scheduler #(.N_REQ(4), .ACK_TIMEOUT(16)) dut (
        .CLK             (clk),
        .RST             (rst_n),
        .REQ_DATA        (req_data),
        .REQ_VALID       (req_valid),
        .REQ_LAST        (req_last),
        .REQ_READY       (req_ready),
        .UART_DATA       (uart_data),
        .UART_DATA_READY (uart_data_ready),
        .UART_IDLE       (uart_idle),
        .GRANT           (grant),
        .BUSY            (busy),
        .TIMEOUT_ERR     (timeout_err),
        .ERR_CLR         (err_clr),
        .DBG_STATE       (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic [7:0] src_mem  [4][8];
    logic       src_last [4][8];
    int         src_len  [4];
    int         src_pos  [4];
    int         rdy_cnt  [4];
    logic [3:0] valid_en;
    logic       model_en;
    int         frame;
    int         busy_cnt;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       idle;
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        logic [3:0] exp_grant;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            if (valid_en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = src_last[i][src_pos[i]];
                req_data[8*i +: 8] = src_mem[i][src_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push_src(input int r, input logic last, input logic [7:0] d);
        src_mem[r][src_len[r]]  = d;
        src_last[r][src_len[r]] = last;
        src_len[r]++;
        drive_srcs();
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            rdy_cnt[i] = 0;
        end
        valid_en = 4'b1111;
        got_q.delete();
        exp_q.delete();
        drive_srcs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        err_clr   = 1'b0;
        uart_idle = 1'b1;
        busy_cnt  = 0;
        clear_srcs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle of the requester queues and the uart_send IDLE model; returns at posedge+1.
    task automatic step_auto();
        logic [3:0] rdy;
        logic       drp;
        @(negedge clk);
        rdy = req_ready;
        drp = uart_data_ready;
        if (drp) got_q.push_back(uart_data);
        for (int i = 0; i < 4; i++) if (rdy[i]) rdy_cnt[i]++;
        @(posedge clk);
        #1;
        if (model_en) begin
            if (drp) begin
                uart_idle = 1'b0;
                busy_cnt  = frame;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) uart_idle = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) if (rdy[i]) src_pos[i]++;
        drive_srcs();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step_auto();
    endtask

    task automatic run_until(input int n, input int max);
        int k;
        k = 0;
        while (got_q.size() < n && k < max) begin
            step_auto();
            k++;
        end
    endtask

    task automatic check_log(input string nm);
        check({nm, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Applies one arbitration vector from S_ARB and hand-walks the byte back to S_ARB.
    task automatic run_vec(input vec_t v, input int n);
        req_valid = v.valid;
        req_last  = v.last;
        uart_idle = v.idle;
        @(negedge clk);
        check($sformatf("vec%0d ready", n), req_ready, v.exp_ready);
        if (v.exp_ready != 4'b0000) begin
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(negedge clk);
            check($sformatf("vec%0d pulse", n), uart_data_ready, 1'b1);
            check($sformatf("vec%0d data", n), uart_data, v.exp_data);
            check($sformatf("vec%0d send grant", n), grant, v.exp_ready);
            @(posedge clk); #1;
            uart_idle = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            uart_idle = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            req_valid = 4'b0000;
            uart_idle = 1'b1;
        end
        @(negedge clk);
        check($sformatf("vec%0d grant", n), grant, v.exp_grant);
        check($sformatf("vec%0d busy", n), busy, 1'b0);
        check($sformatf("vec%0d held data", n), uart_data, v.exp_data);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 8'hA0, 4'b0000};
        vecs[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 8'hA1, 4'b0000};
        vecs[2] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 8'hA3, 4'b0000};
        vecs[3] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 8'hA3, 4'b0000};
        vecs[4] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 8'hA1, 4'b0010};
        vecs[5] = '{4'b1101, 4'b1111, 1'b1, 4'b0000, 8'hA1, 4'b0010};
        vecs[6] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 8'hA1, 4'b0000};
        vecs[7] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 8'hA0, 4'b0000};
        vecs[8] = '{4'b1100, 4'b1111, 1'b1, 4'b0100, 8'hA2, 4'b0000};
        vecs[9] = '{4'b0101, 4'b1111, 1'b1, 4'b0001, 8'hA0, 4'b0000};

        model_en = 1'b0;
        frame    = 5;
        do_reset();

        // Reset state.
        check("rst grant", grant, 4'b0000);
        check("rst busy", busy, 1'b0);
        check("rst data", uart_data, 8'h00);
        check("rst pulse", uart_data_ready, 1'b0);
        check("rst ready", req_ready, 4'b0000);
        check("rst err", timeout_err, 1'b0);
        check("rst state", dbg_state, ST_ARB);

        // Arbitration table with manual IDLE handling.
        req_data = 32'hA3A2A1A0;
        for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

        // Single requester, two-byte packet, 100-cycle frames.
        do_reset();
        model_en = 1'b1;
        frame    = 100;
        push_src(0, 1'b0, 8'h41);
        push_src(0, 1'b1, 8'h42);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        run_until(1, 50);
        check("single mid grant", grant, 4'b0001);
        run_until(2, 300);
        run_cycles(110);
        check_log("single");
        check("single ready count", rdy_cnt[0], 2);
        check("single end grant", grant, 4'b0000);
        check("single end busy", busy, 1'b0);

        // Round-robin fairness: single-byte packets from everyone.
        do_reset();
        frame = 5;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) push_src(i, 1'b1, 8'((i + 1) * 16 + k));
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) exp_q.push_back(8'((i + 1) * 16 + k));
        run_until(8, 300);
        check_log("rr");

        // Packet lock: req1's three bytes go out back to back, then req2.
        do_reset();
        push_src(0, 1'b1, 8'h0A);
        push_src(0, 1'b1, 8'h0B);
        push_src(1, 1'b0, 8'h1A);
        push_src(1, 1'b0, 8'h1B);
        push_src(1, 1'b1, 8'h1C);
        push_src(2, 1'b1, 8'h2A);
        exp_q = '{8'h0A, 8'h1A, 8'h1B, 8'h1C, 8'h2A, 8'h0B};
        run_until(6, 300);
        check_log("lock");

        // Lock stall: req1 goes quiet mid-packet while req0 waits.
        do_reset();
        frame = 10;
        push_src(1, 1'b0, 8'h5A);
        push_src(1, 1'b1, 8'h5B);
        run_until(1, 50);
        valid_en[1] = 1'b0;
        drive_srcs();
        push_src(0, 1'b1, 8'h6A);
        run_cycles(40);
        check("stall bytes", got_q.size(), 1);
        check("stall grant", grant, 4'b0010);
        check("stall busy", busy, 1'b0);
        check("stall req0 ready", rdy_cnt[0], 0);
        valid_en[1] = 1'b1;
        drive_srcs();
        got_q.delete();
        exp_q = '{8'h5B, 8'h6A};
        run_until(2, 100);
        check_log("stall resume");

        // Ack timeout: IDLE never falls.
        do_reset();
        model_en = 1'b0;
        push_src(0, 1'b1, 8'h77);
        run_until(1, 20);
        for (int k = 1; k <= 16; k++) begin
            step_auto();
            if (k == 15) begin
                check("timeout early err", timeout_err, 1'b0);
                check("timeout ack state", dbg_state, ST_ACK);
            end
            if (k == 16) begin
                check("timeout err", timeout_err, 1'b1);
                check("timeout busy", busy, 1'b0);
                check("timeout grant", grant, 4'b0000);
            end
        end
        err_clr = 1'b1;
        step_auto();
        err_clr = 1'b0;
        check("timeout clear", timeout_err, 1'b0);
        got_q.delete();
        err_clr = 1'b1;
        push_src(0, 1'b1, 8'h78);
        run_until(1, 20);
        run_cycles(16);
        check("timeout set wins", timeout_err, 1'b1);
        step_auto();
        check("timeout held clear", timeout_err, 1'b0);
        err_clr = 1'b0;

        // Reset while waiting in S_DONE.
        do_reset();
        model_en = 1'b1;
        frame    = 30;
        push_src(2, 1'b0, 8'h9A);
        push_src(2, 1'b1, 8'h9B);
        run_until(1, 20);
        run_cycles(3);
        check("midrst state", dbg_state, ST_DONE);
        push_src(1, 1'b1, 8'hB1);
        push_src(3, 1'b1, 8'hC3);
        got_q.delete();
        rst_n = 1'b0;
        step_auto();
        check("midrst data", uart_data, 8'h00);
        check("midrst pulse", uart_data_ready, 1'b0);
        check("midrst ready", req_ready, 4'b0000);
        check("midrst grant", grant, 4'b0000);
        check("midrst busy", busy, 1'b0);
        check("midrst err", timeout_err, 1'b0);
        rst_n = 1'b1;
        step_auto();
        check("midrst no pulse", got_q.size(), 0);
        exp_q = '{8'hB1, 8'h9B, 8'hC3};
        run_until(3, 300);
        check_log("midrst order");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
